store_encoder: RTL and testbench
================================

STORE_ENCODER -- requirements
Module: store_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, store data width; only 32 is supported.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, request buffer entries; must be a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, store request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both high at a clock edge.
REQ-008 SHALL have port req_addr, input, ADDRESS_WIDTH, store byte address.
REQ-009 SHALL have port req_wdata, input, DATA_WIDTH, rs2 value, unshifted.
REQ-010 SHALL have port req_funct3, input, 3; 000 = sb, 001 = sh, 010 = sw.
REQ-011 SHALL have port mem_valid, output, 1, memory write presented.
REQ-012 SHALL have port mem_ready, input, 1, memory accepts the write when mem_valid and mem_ready are both high.
REQ-013 SHALL have port mem_addr, output, ADDRESS_WIDTH, word-aligned address with bits [1:0] = 0.
REQ-014 SHALL have port mem_wdata, output, DATA_WIDTH, lane-aligned write data.
REQ-015 SHALL have port mem_be, output, 4, byte-lane enables.
REQ-016 SHALL have port err, output, 1, one-cycle pulse when an accepted request is discarded.
REQ-017 SHALL have port busy, output, 1, high when the FIFO is not empty or the FSM is not IDLE.

Function
REQ-018 SHALL buffer accepted requests in a FIFO of FIFO_DEPTH entries; req_ready = !full.
REQ-019 SHALL set off = addr[1:0] and form an 8-bit byte mask bm: sb 0x01 << off; sh 0x03 << off; sw 0x0F << off.
REQ-020 SHALL form 64-bit data d = zero-extended wdata << (8*off); sb keeps wdata[7:0] only, sh keeps wdata[15:0] only, all other bits zero.
REQ-021 SHALL use FSM states IDLE, LO and HI.
REQ-022 In IDLE with FIFO non-empty, the FSM SHALL pop the head and go to LO on the next cycle; if funct3 is illegal, it SHALL instead pulse err and stay in IDLE.
REQ-023 In LO, the block SHALL drive mem_valid = 1, mem_addr = {addr[AW-1:2], 00}, mem_be = bm[3:0], mem_wdata = d[31:0].
REQ-024 On a LO handshake, the FSM SHALL go to HI if bm[7:4] != 0, else to IDLE.
REQ-025 In HI, the block SHALL drive mem_addr = LO address + 4 (wrapping modulo 2^AW), mem_be = bm[7:4], mem_wdata = d[63:32]; on handshake it SHALL go to IDLE.
REQ-026 mem_valid, mem_addr, mem_be and mem_wdata SHALL stay stable while mem_valid is high and mem_ready is low.
REQ-027 Latency SHALL be 2 cycles from request acceptance to the first mem_valid when the FIFO is empty and the FSM is IDLE; throughput SHALL be one aligned store per 2 cycles.
REQ-028 A push and a pop in the same cycle SHALL both take effect; when full, a same-cycle pop SHALL NOT make req_ready high in that cycle.
REQ-029 Outside LO and HI, mem_valid SHALL be 0 and mem_be SHALL be 0.

Reset
REQ-030 rst SHALL asynchronously clear the FIFO pointers and set the FSM to IDLE, with mem_valid = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, err = 0, busy = 0 and req_ready = 1.
REQ-031 Reset asserted mid-transfer SHALL abandon the store; no half-store is resumed after reset.

Configuration
REQ-032 With macro STORE_MISALIGN_SPLIT_EN defined, a misaligned store (sh with off = 3, or sw with off != 0) SHALL be split into LO and HI word writes per REQ-024 and REQ-025.
REQ-033 Without STORE_MISALIGN_SPLIT_EN, a misaligned store SHALL be popped, produce no memory write, pulse err for one cycle, and return the FSM to IDLE; HI is then unreachable.

Verification
REQ-034 sb, addr 0x102, wdata 0xAABBCCDD -> one write: addr 0x100, be 0100, wdata 0x00DD0000.
REQ-035 sw, addr 0x200, wdata 0x12345678, mem_ready held low for 3 cycles -> outputs stable for those 3 cycles; exactly one write with be 1111.
REQ-036 sh, addr 0x103, wdata 0x0000BEEF, with the macro defined -> write 0x100, be 1000, data 0xEF000000; then write 0x104, be 0001, data 0x000000BE. Without the macro -> no write, err pulses once.
REQ-037 funct3 = 011 -> no memory write, err pulses once, and the following sw completes normally.
REQ-038 Three back-to-back requests with mem_ready = 0 -> req_ready drops after 2 entries are held; releasing mem_ready produces all three writes in order.
REQ-039 rst asserted during HI -> mem_valid = 0 immediately, busy = 0, and no HI write occurs after reset is released.

Source files
------------

// File: rtl/store_encoder.sv
// Store encoder: buffers RISC-V sb/sh/sw requests and emits lane-aligned word writes.
// Optional macro STORE_MISALIGN_SPLIT_EN splits word-crossing stores into LO/HI writes.
module store_encoder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [2:0]               req_funct3,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  output logic                     err,
  output logic                     busy
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [2:0]               funct3;
  } req_t;

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  req_t            r_fifo [FIFO_DEPTH];
  logic [PW:0]     r_wptr, r_rptr;
  state_t          r_state;
  logic [3:0]      r_be_hi;
  logic [31:0]     r_d_hi;
  logic            r_err;

  logic            w_empty, w_full, w_push, w_pop;
  req_t            w_head;
  logic [1:0]      w_off;
  logic [7:0]      w_bm;
  logic [63:0]     w_ext, w_d;
  logic            w_legal, w_mis, w_drop;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push    = req_valid && !w_full;
  assign w_pop     = (r_state == IDLE) && !w_empty;
  assign req_ready = !w_full;
  assign busy      = !w_empty || (r_state != IDLE);
  assign err       = r_err;

  assign w_head = r_fifo[r_rptr[PW-1:0]];
  assign w_off  = w_head.addr[1:0];

  always_comb begin
    w_legal = 1'b1;
    w_bm    = 8'h00;
    w_ext   = 64'd0;
    case (w_head.funct3)
      3'b000: begin w_bm = 8'h01 << w_off; w_ext = {56'd0, w_head.wdata[7:0]};  end
      3'b001: begin w_bm = 8'h03 << w_off; w_ext = {48'd0, w_head.wdata[15:0]}; end
      3'b010: begin w_bm = 8'h0F << w_off; w_ext = {32'd0, w_head.wdata[31:0]}; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_d   = w_ext << {w_off, 3'b000};
  // Any enabled lane above byte 3 means the store crosses into the next word.
  assign w_mis = |w_bm[7:4];

`ifdef STORE_MISALIGN_SPLIT_EN
  assign w_drop = !w_legal;
`else
  assign w_drop = !w_legal || w_mis;
`endif

  // Storage needs no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr[PW-1:0]] <= '{addr: req_addr, wdata: req_wdata, funct3: req_funct3};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'h0;
      r_be_hi   <= 4'h0;
      r_d_hi    <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            if (w_drop) begin
              r_err <= 1'b1;
            end else begin
              r_state   <= LO;
              mem_valid <= 1'b1;
              mem_addr  <= {w_head.addr[ADDRESS_WIDTH-1:2], 2'b00};
              mem_be    <= w_bm[3:0];
              mem_wdata <= w_d[31:0];
              r_be_hi   <= w_bm[7:4];
              r_d_hi    <= w_d[63:32];
            end
          end
        end
        LO: begin
          if (mem_ready) begin
            if (r_be_hi != 4'h0) begin
              r_state   <= HI;
              mem_addr  <= mem_addr + ADDRESS_WIDTH'(4);
              mem_be    <= r_be_hi;
              mem_wdata <= r_d_hi;
            end else begin
              r_state   <= IDLE;
              mem_valid <= 1'b0;
              mem_be    <= 4'h0;
            end
          end
        end
        HI: begin
          if (mem_ready) begin
            r_state   <= IDLE;
            mem_valid <= 1'b0;
            mem_be    <= 4'h0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_encoder.sv
// Directed bench for store_encoder; a posedge monitor logs every memory write and err pulse.
module tb_store_encoder;
  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        err, busy;

  int checks = 0;
  int errors = 0;
  int errcnt = 0;
  logic [67:0] wq[$];

  store_encoder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && mem_valid && mem_ready) wq.push_back({mem_addr, mem_be, mem_wdata});
    if (!rst && err) errcnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_funct3 = f;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin step(); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    logic [67:0] e;
    e = (idx < wq.size()) ? wq[idx] : 68'hx;
    chk({tag, "_addr"}, e[67:36], a);
    chk({tag, "_be"},   e[35:32], be);
    chk({tag, "_data"}, e[31:0],  d);
  endtask

  initial begin
    int n0, e0;
    logic [31:0] va[4], vd[4], ed[4];
    logic [2:0]  vf[4];
    logic [3:0]  eb[4];

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0; mem_ready = 1'b0;
    step(); step();
    chk("rst_valid", mem_valid, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    rst = 1'b0;
    step();

    // sb at offset 2, with first-write latency
    mem_ready = 1'b1;
    n0 = wq.size();
    send(32'h102, 32'hAABBCCDD, 3'b000);
    chk("sb_lat_valid", mem_valid, 0);
    step();
    chk("sb_valid", mem_valid, 1);
    chk("sb_addr", mem_addr, 32'h100);
    chk("sb_be", mem_be, 4'b0100);
    chk("sb_wdata", mem_wdata, 32'h00DD0000);
    step();
    chk("sb_done_valid", mem_valid, 0);
    chk("sb_done_be", mem_be, 0);
    chk("sb_nwr", wq.size() - n0, 1);

    // sw with mem_ready held low for 3 cycles
    mem_ready = 1'b0;
    n0 = wq.size();
    send(32'h200, 32'h12345678, 3'b010);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("sw_hold_valid", mem_valid, 1);
      chk("sw_hold_addr", mem_addr, 32'h200);
      chk("sw_hold_be", mem_be, 4'hF);
      chk("sw_hold_wdata", mem_wdata, 32'h12345678);
      if (i < 2) step();
    end
    mem_ready = 1'b1;
    step();
    chk("sw_done_valid", mem_valid, 0);
    chk("sw_nwr", wq.size() - n0, 1);
    chk_wr("sw_wr", n0, 32'h200, 4'hF, 32'h12345678);

    // sh crossing a word boundary
    n0 = wq.size(); e0 = errcnt;
    send(32'h103, 32'h0000BEEF, 3'b001);
    wait_idle();
    step();
`ifdef STORE_MISALIGN_SPLIT_EN
    chk("mis_nwr", wq.size() - n0, 2);
    chk_wr("mis_lo", n0, 32'h100, 4'b1000, 32'hEF000000);
    chk_wr("mis_hi", n0 + 1, 32'h104, 4'b0001, 32'h000000BE);
    chk("mis_err", errcnt - e0, 0);
`else
    chk("mis_nwr", wq.size() - n0, 0);
    chk("mis_err", errcnt - e0, 1);
`endif

    // illegal funct3 then a normal sw
    n0 = wq.size(); e0 = errcnt;
    send(32'h300, 32'h11111111, 3'b011);
    send(32'h304, 32'hCAFEF00D, 3'b010);
    wait_idle();
    step();
    chk("ill_err", errcnt - e0, 1);
    chk("ill_nwr", wq.size() - n0, 1);
    chk_wr("ill_sw", n0, 32'h304, 4'hF, 32'hCAFEF00D);

    // aligned lane-placement vectors
    va = '{32'h600, 32'h101, 32'h602, 32'h703};
    vd = '{32'h123456A5, 32'hFFFF5678, 32'h1234ABCD, 32'h99887766};
    vf = '{3'b000, 3'b001, 3'b001, 3'b000};
    eb = '{4'b0001, 4'b0110, 4'b1100, 4'b1000};
    ed = '{32'h000000A5, 32'h00567800, 32'hABCD0000, 32'h66000000};
    for (int i = 0; i < 4; i++) begin
      n0 = wq.size();
      send(va[i], vd[i], vf[i]);
      wait_idle();
      chk("vec_nwr", wq.size() - n0, 1);
      chk_wr("vec", n0, {va[i][31:2], 2'b00}, eb[i], ed[i]);
    end

    // back-to-back with memory stalled: FIFO fills
    mem_ready = 1'b0;
    n0 = wq.size();
    send(32'h400, 32'hA0A0A0A0, 3'b010);
    send(32'h404, 32'hB1B1B1B1, 3'b010);
    chk("bb_ready_mid", req_ready, 1);
    send(32'h408, 32'hC2C2C2C2, 3'b010);
    chk("bb_ready_full", req_ready, 0);
    chk("bb_valid", mem_valid, 1);
    chk("bb_addr", mem_addr, 32'h400);
    mem_ready = 1'b1;
    wait_idle();
    step();
    chk("bb_nwr", wq.size() - n0, 3);
    chk_wr("bb0", n0,     32'h400, 4'hF, 32'hA0A0A0A0);
    chk_wr("bb1", n0 + 1, 32'h404, 4'hF, 32'hB1B1B1B1);
    chk_wr("bb2", n0 + 2, 32'h408, 4'hF, 32'hC2C2C2C2);

    // reset mid-transfer abandons the store
    mem_ready = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
    send(32'h103, 32'h0000BEEF, 3'b001);
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("hi_valid", mem_valid, 1);
    chk("hi_addr", mem_addr, 32'h104);
    chk("hi_be", mem_be, 4'b0001);
`else
    send(32'h500, 32'h55555555, 3'b010);
    step();
    chk("lo_valid", mem_valid, 1);
`endif
    n0 = wq.size();
    rst = 1'b1;
    #1;
    chk("arst_valid", mem_valid, 0);
    chk("arst_be", mem_be, 0);
    chk("arst_busy", busy, 0);
    step();
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (4) step();
    chk("arst_nwr", wq.size() - n0, 0);
    chk("arst_valid2", mem_valid, 0);
    chk("arst_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
